// File: rtl/noisy_bit_channel.sv
// noisy_bit_channel: loop-back model of a noisy digital link.
//
// Each input bit is turned into a 25-bit amplitude symbol ({bit, 24'b0}).
// One shared noise sample from the awgn generator is added to every symbol.
// The receiver slices bit 24 of each noisy symbol to recover the byte.
// The noise is always below 2^24 and the low 24 bits of a symbol are zero,
// so the addition never carries into bit 24. The link is therefore
// error-free with one cycle of latency.
//
// awgn ports:
//   clk, reset      - clock, synchronous active-high reset
//   en              - advance the LFSRs and the warm-up counter
//   seed, seed_load - reseed both LFSRs and restart warm-up (wins over en)
//   busy            - high during warm-up; the noise outputs are zero then
//   y_real, y_imag  - registered, scaled noise samples
//   sum_trunc       - y_real was saturated this cycle
//
// noisy_bit_channel ports:
//   clk, reset      - clock, synchronous active-high reset
//   data_in         - byte to transmit
//   data_out        - recovered byte, one cycle after data_in

module awgn #(
    parameter int NOISE_SHIFT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [23:0] seed,
    input  logic        seed_load,
    output logic        busy,
    output logic [23:0] y_real,
    output logic [23:0] y_imag,
    output logic        sum_trunc
);

    localparam logic [31:0] TAP_MASK = 32'h8020_0003;
    localparam logic [31:0] A_RESET  = 32'hDEAD_BEEF;
    localparam logic [31:0] B_RESET  = 32'h1234_5678;
    localparam logic [2:0]  WARMUP   = 3'd4;
    localparam logic [63:0] Y_MAX    = 64'h0000_0000_00FF_FFFF;

    logic [31:0] lfsr_a_q, lfsr_a_d;
    logic [31:0] lfsr_b_q, lfsr_b_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [23:0] y_real_q, y_real_d;
    logic [23:0] y_imag_q, y_imag_d;
    logic        trunc_q, trunc_d;

    logic [9:0]  sum_re, sum_im;
    logic [63:0] wide_re, wide_im;
    logic        sat_re, sat_im;
    logic [23:0] scaled_re, scaled_im;

    // Galois step: shift right, fold the tap mask in when a one falls out.
    // Bit 31 of the mask is set, so a nonzero state never maps to zero.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? TAP_MASK : 32'h0);
    endfunction

    // The sum of four uniform bytes is a cheap central-limit approximation
    // of Gaussian noise.
    function automatic logic [9:0] byte_sum(input logic [31:0] s);
        return 10'(s[7:0]) + 10'(s[15:8]) + 10'(s[23:16]) + 10'(s[31:24]);
    endfunction

    always_comb begin
        sum_re    = byte_sum(lfsr_a_q);
        sum_im    = byte_sum(lfsr_b_q);
        wide_re   = 64'(sum_re) << NOISE_SHIFT;
        wide_im   = 64'(sum_im) << NOISE_SHIFT;
        sat_re    = (wide_re > Y_MAX);
        sat_im    = (wide_im > Y_MAX);
        scaled_re = sat_re ? 24'hFF_FFFF : wide_re[23:0];
        scaled_im = sat_im ? 24'hFF_FFFF : wide_im[23:0];
    end

    always_comb begin
        lfsr_a_d = lfsr_a_q;
        lfsr_b_d = lfsr_b_q;
        cnt_d    = cnt_q;
        y_real_d = y_real_q;
        y_imag_d = y_imag_q;
        trunc_d  = trunc_q;
        if (seed_load) begin
            // OR in a one so a zero seed cannot lock up the LFSRs.
            lfsr_a_d = {8'h00, seed} | 32'h1;
            lfsr_b_d = {seed, 8'hA5} | 32'h1;
            cnt_d    = 3'd0;
            y_real_d = 24'h0;
            y_imag_d = 24'h0;
            trunc_d  = 1'b0;
        end else if (en) begin
            lfsr_a_d = lfsr_next(lfsr_a_q);
            lfsr_b_d = lfsr_next(lfsr_b_q);
            cnt_d    = (cnt_q < WARMUP) ? cnt_q + 3'd1 : cnt_q;
            // Use the next count so the first noise sample appears on the
            // same edge that busy drops.
            if (cnt_d < WARMUP) begin
                y_real_d = 24'h0;
                y_imag_d = 24'h0;
                trunc_d  = 1'b0;
            end else begin
                y_real_d = scaled_re;
                y_imag_d = scaled_im;
                trunc_d  = sat_re;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_a_q <= A_RESET;
            lfsr_b_q <= B_RESET;
            cnt_q    <= 3'd0;
            y_real_q <= 24'h0;
            y_imag_q <= 24'h0;
            trunc_q  <= 1'b0;
        end else begin
            lfsr_a_q <= lfsr_a_d;
            lfsr_b_q <= lfsr_b_d;
            cnt_q    <= cnt_d;
            y_real_q <= y_real_d;
            y_imag_q <= y_imag_d;
            trunc_q  <= trunc_d;
        end
    end

    assign busy      = (cnt_q < WARMUP);
    assign y_real    = y_real_q;
    assign y_imag    = y_imag_q;
    assign sum_trunc = trunc_q;

endmodule

module noisy_bit_channel #(
    parameter int N_BITS      = 8,
    parameter int NOISE_SHIFT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_BITS-1:0] data_in,
    output logic [N_BITS-1:0] data_out
);

    logic [N_BITS-1:0][24:0] sym_q, sym_d;
    logic [24:0]             noisy [N_BITS];
    logic [N_BITS-1:0]       noisy_lo;

    logic [23:0] y_real, y_imag;
    logic        busy, sum_trunc;
    logic [23:0] seed_w;

    assign seed_w = 24'(data_in);

    awgn #(
        .NOISE_SHIFT(NOISE_SHIFT)
    ) u_awgn (
        .clk       (clk),
        .reset     (reset),
        .en        (1'b1),
        .seed      (seed_w),
        .seed_load (1'b0),
        .busy      (busy),
        .y_real    (y_real),
        .y_imag    (y_imag),
        .sum_trunc (sum_trunc)
    );

    always_comb begin
        sym_d = '0;
        for (int i = 0; i < N_BITS; i++) begin
            sym_d[i] = {data_in[i], 24'h0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sym_q <= '0;
        end else begin
            sym_q <= sym_d;
        end
    end

    for (genvar g = 0; g < N_BITS; g++) begin : g_rx
        assign noisy[g]    = sym_q[g] + {1'b0, y_real};
        assign data_out[g] = noisy[g][24];
        assign noisy_lo[g] = ^noisy[g][23:0];
    end

    // Noise amplitudes and the imaginary path are not consumed by the slicer.
    logic unused_sink;
    assign unused_sink = ^{noisy_lo, y_imag, busy, sum_trunc};

endmodule

// File: tb/tb_noisy_bit_channel.sv
module tb_noisy_bit_channel;

    localparam logic [31:0] MASK    = 32'h8020_0003;
    localparam logic [31:0] A_RESET = 32'hDEAD_BEEF;
    localparam logic [31:0] B_RESET = 32'h1234_5678;
    localparam int          SEQ_LEN = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic [7:0] data_out;

    logic        rst2, en2, ld2;
    logic [23:0] seed2;
    logic        busy2, trunc2;
    logic [23:0] y2_re, y2_im;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] seq_a [SEQ_LEN];
    logic [31:0] seq_b [SEQ_LEN];

    int          k;
    logic [7:0]  exp_d;
    int          k2;
    logic [31:0] m2, prev2;

    always #5 clk = ~clk;

    noisy_bit_channel dut (
        .clk      (clk),
        .reset    (rst),
        .data_in  (din),
        .data_out (data_out)
    );

    awgn #(.NOISE_SHIFT(16)) u_awgn16 (
        .clk       (clk),
        .reset     (rst2),
        .en        (en2),
        .seed      (seed2),
        .seed_load (ld2),
        .busy      (busy2),
        .y_real    (y2_re),
        .y_imag    (y2_im),
        .sum_trunc (trunc2)
    );

    function automatic logic [31:0] step(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ MASK;
        return r;
    endfunction

    function automatic int bsum(input logic [31:0] s);
        return int'(s[7:0]) + int'(s[15:8]) + int'(s[23:16]) + int'(s[31:24]);
    endfunction

    function automatic logic [31:0] scale(input int sum, input int mult);
        longint v;
        v = longint'(sum) * longint'(mult);
        if (v >= 64'd16777216) return 32'h00FF_FFFF;
        return 32'(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: sample after the edge, advance both reference models with
    // the inputs that were present at the edge, and compare.
    task automatic tick();
        logic [31:0] ey, ei, ey2;
        logic        et2;
        @(posedge clk);
        #1;
        if (rst) begin
            k = 0;
            exp_d = 8'h00;
        end else begin
            if (k < SEQ_LEN - 1) k++;
            exp_d = din;
        end
        ey = (k < 4) ? 32'h0 : scale(bsum(seq_a[k-1]), 256);
        ei = (k < 4) ? 32'h0 : scale(bsum(seq_b[k-1]), 256);
        check("data_out", {24'h0, data_out}, {24'h0, exp_d});
        check("busy", {31'h0, dut.u_awgn.busy}, {31'h0, (k < 4)});
        check("y_real", {8'h0, dut.u_awgn.y_real}, ey);
        check("y_imag", {8'h0, dut.u_awgn.y_imag}, ei);

        if (rst2) begin
            k2 = 0;
            m2 = A_RESET;
        end else if (ld2) begin
            k2 = 0;
            m2 = {8'h00, seed2} | 32'h1;
        end else begin
            prev2 = m2;
            m2 = step(m2);
            if (k2 < 4) k2++;
        end
        ey2 = (k2 < 4) ? 32'h0 : scale(bsum(prev2), 65536);
        et2 = (k2 >= 4) && (bsum(prev2) >= 256);
        check("awgn16_y", {8'h0, y2_re}, ey2);
        check("awgn16_trunc", {31'h0, trunc2}, {31'h0, et2});
        check("awgn16_busy", {31'h0, busy2}, {31'h0, (k2 < 4)});
        check("awgn16_lfsr_a", u_awgn16.lfsr_a_q, m2);
    endtask

    typedef struct {
        bit         rst;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[$];

    initial begin
        int busy_cnt;
        int trunc_cnt;
        logic [7:0] pat [4];

        rst   = 1'b1;
        din   = 8'h00;
        rst2  = 1'b1;
        en2   = 1'b1;
        ld2   = 1'b0;
        seed2 = 24'h0;
        k     = 0;
        k2    = 0;
        m2    = A_RESET;
        prev2 = A_RESET;
        exp_d = 8'h00;

        seq_a[0] = A_RESET;
        seq_b[0] = B_RESET;
        for (int i = 1; i < SEQ_LEN; i++) begin
            seq_a[i] = step(seq_a[i-1]);
            seq_b[i] = step(seq_b[i-1]);
        end

        // Table: reset, four held patterns, reset mid-stream, recovery.
        pat[0] = 8'hAA; pat[1] = 8'h66; pat[2] = 8'h00; pat[3] = 8'h3F;
        vt.push_back('{1'b1, 8'h5A, 8'h00});
        vt.push_back('{1'b1, 8'hC3, 8'h00});
        for (int p = 0; p < 4; p++)
            for (int j = 0; j < 15; j++)
                vt.push_back('{1'b0, pat[p], pat[p]});
        vt.push_back('{1'b1, 8'hFF, 8'h00});
        for (int j = 0; j < 3; j++)
            vt.push_back('{1'b0, 8'h81, 8'h81});

        for (int i = 0; i < vt.size(); i++) begin
            rst  = vt[i].rst;
            din  = vt[i].din;
            rst2 = (i < 2);
            tick();
            check("tbl_dout", {24'h0, data_out}, {24'h0, vt[i].exp});
        end

        // Randomised traffic with occasional resets and reseeds.
        for (int i = 0; i < 1000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            din   = 8'($urandom);
            rst2  = ($urandom_range(0, 149) == 0);
            ld2   = ($urandom_range(0, 99) == 0);
            seed2 = 24'($urandom);
            tick();
        end
        rst2 = 1'b0;
        ld2  = 1'b0;

        // Two resets separated by traffic; model checks both windows, and the
        // noise must be nonzero and in range once warm-up ends.
        for (int r = 0; r < 2; r++) begin
            rst = 1'b1;
            tick();
            tick();
            rst = 1'b0;
            for (int j = 0; j < 36; j++) begin
                din = 8'($urandom);
                tick();
                if (j >= 3) begin
                    check("y_range",
                          {31'h0, (dut.u_awgn.y_real != 24'h0) &&
                                  (dut.u_awgn.y_real <= 24'd261120)},
                          32'h1);
                end
            end
            for (int j = 0; j < 17; j++) begin
                din = 8'($urandom);
                tick();
            end
        end

        // Zero seed: LFSR A must become 1 and warm-up restarts.
        ld2   = 1'b1;
        seed2 = 24'h0;
        tick();
        check("seed0_lfsr_a", u_awgn16.lfsr_a_q, 32'h0000_0001);
        ld2 = 1'b0;
        busy_cnt = busy2 ? 1 : 0;
        for (int j = 0; j < 6; j++) begin
            tick();
            if (busy2) busy_cnt++;
        end
        check("seed0_busy_cycles", busy_cnt, 32'd4);

        // Reset wins over a simultaneous seed load.
        rst2  = 1'b1;
        ld2   = 1'b1;
        seed2 = 24'h123456;
        tick();
        check("rst_beats_load", u_awgn16.lfsr_a_q, A_RESET);
        rst2 = 1'b0;
        ld2  = 1'b0;

        // Long free run with NOISE_SHIFT=16: saturation must occur.
        trunc_cnt = 0;
        for (int j = 0; j < 300; j++) begin
            din = 8'($urandom);
            tick();
            if (trunc2) trunc_cnt++;
        end
        check("trunc_seen", {31'h0, (trunc_cnt > 0)}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
